// File: rtl/kul8_seq_sched.sv
// Sequential 8x8 approximate multiplier: one Kul4 4x4 core time-shared over four steps.
// Optional macro KUL_SEQ_ZERO_SKIP_EN: zero operands bypass CALC and finish on the accept edge.
module kul8_seq_sched #(
    parameter int REG_PP = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] y,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [15:0] acc_q, acc_d;
    logic [1:0]  step_q, step_d;
    logic [15:0] term_q, term_d;
    logic [15:0] y_q, y_d;

    logic [3:0]  a_nib;
    logic [3:0]  b_nib;
    logic [7:0]  pp;
    logic [15:0] term_now;

    // 2x2 digit product: exact except 3x3, which gives 7
    function automatic logic [3:0] kul2(input logic [1:0] x, input logic [1:0] w);
        logic [3:0] p;
        p = {2'b00, x} * {2'b00, w};
        if (x == 2'd3 && w == 2'd3) begin
            p = 4'd7;
        end
        return p;
    endfunction

    function automatic logic [7:0] kul4(input logic [3:0] x, input logic [3:0] w);
        logic [7:0] p00, p10, p01, p11;
        p00 = {4'b0000, kul2(x[1:0], w[1:0])};
        p10 = {4'b0000, kul2(x[3:2], w[1:0])};
        p01 = {4'b0000, kul2(x[1:0], w[3:2])};
        p11 = {4'b0000, kul2(x[3:2], w[3:2])};
        return p00 + (p10 << 2) + (p01 << 2) + (p11 << 4);
    endfunction

    // Step bit 0 picks the a nibble, bit 1 the b nibble; shift is the sum of nibble weights
    always_comb begin
        a_nib = step_q[0] ? a_q[7:4] : a_q[3:0];
        b_nib = step_q[1] ? b_q[7:4] : b_q[3:0];
        pp    = kul4(a_nib, b_nib);
        case (step_q)
            2'd0:    term_now = {8'h00, pp};
            2'd3:    term_now = {pp, 8'h00};
            default: term_now = {4'h0, pp, 4'h0};
        endcase
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        step_d  = step_q;
        term_d  = term_q;
        y_d     = y_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    step_d  = '0;
                    term_d  = '0;
`ifdef KUL_SEQ_ZERO_SKIP_EN
                    if (a == 8'h00 || b == 8'h00) begin
                        y_d     = '0;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_CALC;
                    end
`else
                    state_d = S_CALC;
`endif
                end
            end
            S_CALC: begin
                step_d = step_q + 2'd1;
                if (REG_PP != 0) begin
                    // Pipelined: add the product registered on the previous edge
                    term_d = term_now;
                    acc_d  = acc_q + term_q;
                    if (step_q == 2'd3) begin
                        state_d = S_FLUSH;
                    end
                end else begin
                    acc_d = acc_q + term_now;
                    if (step_q == 2'd3) begin
                        y_d     = acc_q + term_now;
                        state_d = S_DONE;
                    end
                end
            end
            S_FLUSH: begin
                acc_d   = acc_q + term_q;
                y_d     = acc_q + term_q;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            step_q  <= '0;
            term_q  <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            step_q  <= step_d;
            term_q  <= term_d;
            y_q     <= y_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign y         = y_q;

endmodule
